morra_tabellone: RTL

Scoreboard stage directly downstream of the morra cinese game FSM. Samples the FSM's per-cycle `manche` and `partita` codes and keeps per-game counts: P1 wins, P2 wins, draws, invalid manche, total manche. Latches each game's final result behind a valid/ack handshake and keeps cumulative per-series win counters. Sits between the game FSM and the display/host readout logic.

---
 rtl/morra_pkg.sv | 25 ++
 rtl/contatore_sat.sv | 34 +++
 rtl/morra_tabellone.sv | 123 ++++++++++++
 3 files changed

// File: rtl/morra_pkg.sv
// Shared encodings between the morra game FSM and its scoreboard stage.
package morra_pkg;

  typedef enum logic [1:0] {
    MANCHE_NONE = 2'b00,
    MANCHE_P1   = 2'b01,
    MANCHE_P2   = 2'b10,
    MANCHE_PAR  = 2'b11
  } manche_e;

  typedef enum logic [1:0] {
    PARTITA_CORSO = 2'b00,
    PARTITA_P1    = 2'b01,
    PARTITA_P2    = 2'b10,
    PARTITA_PAR   = 2'b11
  } partita_e;

  typedef enum logic [1:0] {
    ATTESA   = 2'b00,
    IN_GIOCO = 2'b01,
    CONCLUSA = 2'b10,
    ILLEGALE = 2'b11
  } stato_e;

endpackage

// File: rtl/contatore_sat.sv
// Saturating up-counter with synchronous clear taking priority over enable.
module contatore_sat #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/morra_tabellone.sv
// Scoreboard for the morra game FSM: per-game tallies, latched result with
// valid/ack handshake, and cumulative series counters.
module morra_tabellone
  import morra_pkg::*;
#(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned SERIE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inizia,
  input  logic [1:0]         manche,
  input  logic [1:0]         partita,
  input  logic               letto,
  output logic [CNT_W-1:0]   vinte_p1,
  output logic [CNT_W-1:0]   vinte_p2,
  output logic [CNT_W-1:0]   pareggi,
  output logic [CNT_W-1:0]   non_valide,
  output logic [CNT_W-1:0]   giocate,
  output logic [1:0]         esito,
  output logic               esito_valido,
  output logic               perso,
  output logic [SERIE_W-1:0] serie_p1,
  output logic [SERIE_W-1:0] serie_p2,
  output logic [SERIE_W-1:0] serie_par,
  output logic [1:0]         stato
);

  stato_e     state_q, state_d;
  logic [1:0] esito_q, esito_d;
  logic       valido_q, valido_d;
  logic       perso_q, perso_d;

  logic conta, conclusione, ack;
  logic inc_p1, inc_p2, inc_par, inc_nv, inc_gioc;
  logic inc_s1, inc_s2, inc_spar;

  // Only a running game with no restart this cycle feeds the tallies.
  always_comb begin
    conta       = (state_q == IN_GIOCO) && !inizia;
    conclusione = conta && (partita != PARTITA_CORSO);
    ack         = letto && valido_q;
    inc_p1      = conta && (manche == MANCHE_P1);
    inc_p2      = conta && (manche == MANCHE_P2);
    inc_par     = conta && (manche == MANCHE_PAR);
    inc_nv      = conta && !conclusione && (manche == MANCHE_NONE);
    inc_gioc    = conta && (manche != MANCHE_NONE);
    inc_s1      = conclusione && (partita == PARTITA_P1);
    inc_s2      = conclusione && (partita == PARTITA_P2);
    inc_spar    = conclusione && (partita == PARTITA_PAR);
  end

  always_comb begin
    state_d = state_q;
    if (inizia) begin
      state_d = IN_GIOCO;
    end else begin
      case (state_q)
        ATTESA:   state_d = ATTESA;
        IN_GIOCO: state_d = conclusione ? CONCLUSA : IN_GIOCO;
        CONCLUSA: state_d = CONCLUSA;
        default:  state_d = ATTESA;
      endcase
    end
  end

  // An ack in the conclusion cycle consumes the old result, so no loss is flagged.
  always_comb begin
    esito_d  = esito_q;
    valido_d = valido_q;
    perso_d  = perso_q;
    if (ack) begin
      valido_d = 1'b0;
      perso_d  = 1'b0;
    end
    if (conclusione) begin
      esito_d  = partita;
      valido_d = 1'b1;
      if (valido_q && !letto) begin
        perso_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ATTESA;
      esito_q  <= 2'b00;
      valido_q <= 1'b0;
      perso_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      esito_q  <= esito_d;
      valido_q <= valido_d;
      perso_q  <= perso_d;
    end
  end

  assign stato        = state_q;
  assign esito        = esito_q;
  assign esito_valido = valido_q;
  assign perso        = perso_q;

  contatore_sat #(.W(CNT_W)) u_vinte_p1 (
    .clk(clk), .rst_n(rst_n), .clr(inizia), .en(inc_p1), .q(vinte_p1));
  contatore_sat #(.W(CNT_W)) u_vinte_p2 (
    .clk(clk), .rst_n(rst_n), .clr(inizia), .en(inc_p2), .q(vinte_p2));
  contatore_sat #(.W(CNT_W)) u_pareggi (
    .clk(clk), .rst_n(rst_n), .clr(inizia), .en(inc_par), .q(pareggi));
  contatore_sat #(.W(CNT_W)) u_non_valide (
    .clk(clk), .rst_n(rst_n), .clr(inizia), .en(inc_nv), .q(non_valide));
  contatore_sat #(.W(CNT_W)) u_giocate (
    .clk(clk), .rst_n(rst_n), .clr(inizia), .en(inc_gioc), .q(giocate));

  // Series counters only ever clear on reset.
  contatore_sat #(.W(SERIE_W)) u_serie_p1 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(inc_s1), .q(serie_p1));
  contatore_sat #(.W(SERIE_W)) u_serie_p2 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(inc_s2), .q(serie_p2));
  contatore_sat #(.W(SERIE_W)) u_serie_par (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(inc_spar), .q(serie_par));

endmodule
